// File: rtl/pp_st3_ctrl.sv
// Ping-pong sequencer for pp_st3: counts write beats, swaps banks, and drains read rows to a consumer.
// Rows appear LATENCY cycles after a swap or acceptance; out_valid holds with raddr/sel frozen under backpressure.
module pp_st3_ctrl #(
    parameter int IN_ADDR_WIDTH  = 7,
    parameter int OUT_ADDR_WIDTH = 2,
    parameter int CHANNEL_NUM    = 4,
    parameter int WR_BEATS       = 2**IN_ADDR_WIDTH,
    parameter int LATENCY        = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic                      st3_sel,
    output logic                      st3_wen,
    output logic [IN_ADDR_WIDTH-1:0]  st3_waddr,
    output logic [OUT_ADDR_WIDTH-1:0] st3_raddr,
    output logic                      wr_full,
    output logic                      rd_active
);

    localparam int LCNT_W = $clog2(LATENCY + 1);
    localparam logic [LCNT_W-1:0]         LAT_LOAD  = LCNT_W'(LATENCY);
    localparam logic [LCNT_W-1:0]         LCNT_ONE  = LCNT_W'(1);
    localparam logic [IN_ADDR_WIDTH-1:0]  LAST_BEAT = IN_ADDR_WIDTH'(WR_BEATS - 1);
    localparam logic [IN_ADDR_WIDTH-1:0]  WONE      = IN_ADDR_WIDTH'(1);
    localparam logic [OUT_ADDR_WIDTH-1:0] LAST_ROW  = OUT_ADDR_WIDTH'(CHANNEL_NUM - 1);
    localparam logic [OUT_ADDR_WIDTH-1:0] RONE      = OUT_ADDR_WIDTH'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_VALID = 2'd2;

    logic [1:0]               rstate;
    logic [LCNT_W-1:0]        lcnt;
    logic [IN_ADDR_WIDTH-1:0] wcnt;
    logic                     row_take;
    logic                     swap;

    assign st3_waddr = wcnt;
    assign in_ready  = !wr_full && !flush;
    assign st3_wen   = in_valid && in_ready;
    assign out_valid = (rstate == S_VALID);
    assign out_last  = out_valid && (st3_raddr == LAST_ROW);
    assign row_take  = out_valid && out_ready;
    assign swap      = wr_full && (!rd_active || (row_take && out_last));

    // Beat acceptance needs !wr_full and swap needs wr_full, so the two never coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt    <= '0;
            wr_full <= 1'b0;
        end else if (flush) begin
            wcnt    <= '0;
            wr_full <= 1'b0;
        end else if (st3_wen) begin
            if (wcnt == LAST_BEAT) begin
                wcnt    <= '0;
                wr_full <= 1'b1;
            end else begin
                wcnt <= wcnt + WONE;
            end
        end else if (swap) begin
            wr_full <= 1'b0;
        end
    end

    // A swap outranks the normal last-row retire so a waiting full bank starts draining at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st3_sel   <= 1'b0;
            rd_active <= 1'b0;
            st3_raddr <= '0;
            rstate    <= S_IDLE;
            lcnt      <= '0;
        end else if (flush) begin
            rd_active <= 1'b0;
            st3_raddr <= '0;
            rstate    <= S_IDLE;
            lcnt      <= '0;
        end else if (swap) begin
            st3_sel   <= ~st3_sel;
            rd_active <= 1'b1;
            st3_raddr <= '0;
            rstate    <= S_WAIT;
            lcnt      <= LAT_LOAD;
        end else begin
            case (rstate)
                S_WAIT: begin
                    lcnt <= lcnt - LCNT_ONE;
                    if (lcnt == LCNT_ONE) begin
                        rstate <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (out_ready) begin
                        if (out_last) begin
                            rd_active <= 1'b0;
                            rstate    <= S_IDLE;
                        end else begin
                            st3_raddr <= st3_raddr + RONE;
                            rstate    <= S_WAIT;
                            lcnt      <= LAT_LOAD;
                        end
                    end
                end
                default: rstate <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pp_st3_ctrl.sv
// Directed bench for pp_st3_ctrl: default instance (LATENCY 1) plus a LATENCY 3 / 8-beat instance.
// Expected rows are queued when a bank is filled and checked as the consumer accepts them.
module tb_pp_st3_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, flush, in_valid, out_ready;
    logic       in_ready, out_valid, out_last, st3_sel, st3_wen, wr_full, rd_active;
    logic [6:0] st3_waddr;
    logic [1:0] st3_raddr;
    logic       b_in_ready, b_out_valid, b_out_last, b_st3_sel, b_st3_wen, b_wr_full, b_rd_active;
    logic [6:0] b_st3_waddr;
    logic [1:0] b_st3_raddr;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic       sel;
        logic [1:0] row;
        logic       last;
    } row_t;
    row_t sb[$];

    pp_st3_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .st3_sel(st3_sel),
        .st3_wen(st3_wen), .st3_waddr(st3_waddr), .st3_raddr(st3_raddr),
        .wr_full(wr_full), .rd_active(rd_active)
    );

    pp_st3_ctrl #(.LATENCY(3), .WR_BEATS(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_last(b_out_last), .st3_sel(b_st3_sel),
        .st3_wen(b_st3_wen), .st3_waddr(b_st3_waddr), .st3_raddr(b_st3_raddr),
        .wr_full(b_wr_full), .rd_active(b_rd_active)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic wait_b_valid(output int n);
        n = 0;
        while (b_out_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic push_bank(input logic s);
        for (int r = 0; r < 4; r++) sb.push_back(row_t'({s, 2'(r), (r == 3)}));
    endtask

    task automatic fill(input int beats, input string tag);
        int guard;
        for (int i = 0; i < beats; i++) begin
            in_valid = 1'b1;
            #1;
            guard = 0;
            while (in_ready !== 1'b1 && guard < 300) begin
                step();
                guard++;
            end
            chk({tag, "_waddr"}, 32'(st3_waddr), i);
            chk({tag, "_wen"}, 32'(st3_wen), 1);
            step();
        end
        in_valid = 1'b0;
    endtask

    // Consumer side: every accepted row must match the next queued expectation.
    always @(negedge clk) begin : mon
        row_t e;
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            chk("row_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("row_sel", 32'(st3_sel), 32'(e.sel));
                chk("row_raddr", 32'(st3_raddr), 32'(e.row));
                chk("row_last", 32'(out_last), 32'(e.last));
            end
        end
    end

    initial begin
        int n;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step(); step();
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_sel", 32'(st3_sel), 0);
        chk("rst_waddr", 32'(st3_waddr), 0);
        chk("rst_raddr", 32'(st3_raddr), 0);
        chk("rst_wr_full", 32'(wr_full), 0);
        chk("rst_rd_active", 32'(rd_active), 0);
        chk("rst_wen", 32'(st3_wen), 0);
        chk("rst_b_in_ready", 32'(b_in_ready), 1);
        rst_n = 1'b1;
        step();
        chk("idle_in_ready", 32'(in_ready), 1);
        chk("idle_out_valid", 32'(out_valid), 0);

        // Single fill and drain with a 10-cycle stall on row 1.
        fill(128, "fill1");
        chk("fill1_wr_full", 32'(wr_full), 1);
        chk("fill1_in_ready", 32'(in_ready), 0);
        chk("fill1_sel", 32'(st3_sel), 0);
        push_bank(1'b1);
        step();
        chk("swap1_sel", 32'(st3_sel), 1);
        chk("swap1_wr_full", 32'(wr_full), 0);
        chk("swap1_rd_active", 32'(rd_active), 1);
        chk("swap1_raddr", 32'(st3_raddr), 0);
        chk("swap1_out_valid", 32'(out_valid), 0);
        chk("swap1_in_ready", 32'(in_ready), 1);
        wait_valid(n);
        chk("first_row_lat", n, 1);
        step();
        wait_valid(n);
        chk("row1_gap", n, 1);
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("bp_raddr", 32'(st3_raddr), 1);
            chk("bp_out_valid", 32'(out_valid), 1);
        end
        out_ready = 1'b1;
        step();
        for (int r = 2; r < 4; r++) begin
            wait_valid(n);
            chk("drain_gap", n, 1);
            chk("drain_last", 32'(out_last), 32'(r == 3));
            step();
        end
        chk("drain_rd_active", 32'(rd_active), 0);
        chk("drain_out_valid", 32'(out_valid), 0);
        chk("drain_sb_empty", 32'(sb.size()), 0);

        // Concurrent swap: second bank fills while the first holds row 0.
        out_ready = 1'b0;
        fill(128, "fill2");
        push_bank(1'b0);
        step();
        chk("swap2_sel", 32'(st3_sel), 0);
        fill(128, "fill3");
        chk("fill3_wr_full", 32'(wr_full), 1);
        chk("fill3_out_valid", 32'(out_valid), 1);
        chk("fill3_raddr", 32'(st3_raddr), 0);
        push_bank(1'b1);
        out_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            wait_valid(n);
            step();
        end
        wait_valid(n);
        chk("cs_row3_last", 32'(out_last), 1);
        chk("cs_row3_wr_full", 32'(wr_full), 1);
        step();
        chk("cs_sel", 32'(st3_sel), 1);
        chk("cs_raddr", 32'(st3_raddr), 0);
        chk("cs_out_valid", 32'(out_valid), 0);
        chk("cs_rd_active", 32'(rd_active), 1);
        chk("cs_wr_full", 32'(wr_full), 0);
        chk("cs_in_ready", 32'(in_ready), 1);
        wait_valid(n);
        chk("cs_lat", n, 1);

        // Flush with 50 beats written and row 2 held valid.
        step();
        wait_valid(n);
        step();
        wait_valid(n);
        out_ready = 1'b0;
        chk("fl_pre_raddr", 32'(st3_raddr), 2);
        fill(50, "fill4");
        chk("fl_pre_waddr", 32'(st3_waddr), 50);
        chk("fl_pre_out_valid", 32'(out_valid), 1);
        flush = 1'b1;
        #1;
        chk("fl_in_ready", 32'(in_ready), 0);
        step();
        flush = 1'b0;
        chk("fl_waddr", 32'(st3_waddr), 0);
        chk("fl_out_valid", 32'(out_valid), 0);
        chk("fl_rd_active", 32'(rd_active), 0);
        chk("fl_wr_full", 32'(wr_full), 0);
        chk("fl_raddr", 32'(st3_raddr), 0);
        chk("fl_sel", 32'(st3_sel), 1);
        chk("fl_rows_left", 32'(sb.size()), 2);
        sb.delete();
        out_ready = 1'b1;
        fill(128, "fill5");
        push_bank(1'b0);
        step();
        chk("swap5_sel", 32'(st3_sel), 0);
        for (int r = 0; r < 4; r++) begin
            wait_valid(n);
            chk("drain5_gap", n, 1);
            step();
        end
        chk("drain5_sb_empty", 32'(sb.size()), 0);
        chk("drain5_rd_active", 32'(rd_active), 0);

        // LATENCY 3, 8-beat instance.
        rst_n = 1'b0;
        #1;
        chk("b_rst_sel", 32'(b_st3_sel), 0);
        chk("b_rst_rd_active", 32'(b_rd_active), 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            #1;
            chk("b_waddr", 32'(b_st3_waddr), i);
            chk("b_wen", 32'(b_st3_wen), 1);
            step();
        end
        in_valid = 1'b0;
        chk("b_wr_full", 32'(b_wr_full), 1);
        chk("b_waddr_wrap", 32'(b_st3_waddr), 0);
        chk("b_in_ready_full", 32'(b_in_ready), 0);
        step();
        chk("b_swap_sel", 32'(b_st3_sel), 1);
        wait_b_valid(n);
        chk("b_first_lat", n, 3);
        for (int r = 0; r < 4; r++) begin
            chk("b_raddr", 32'(b_st3_raddr), r);
            chk("b_out_last", 32'(b_out_last), 32'(r == 3));
            step();
            if (r < 3) begin
                wait_b_valid(n);
                chk("b_row_gap", n, 3);
            end
        end
        chk("b_drain_rd_active", 32'(b_rd_active), 0);
        chk("b_drain_out_valid", 32'(b_out_valid), 0);

        // Reset mid-fill drops all accepted beats.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            step();
        end
        chk("b_midfill_waddr", 32'(b_st3_waddr), 3);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("b_rst_waddr", 32'(b_st3_waddr), 0);
        chk("b_rst_sel2", 32'(b_st3_sel), 0);
        chk("a_rst_waddr", 32'(st3_waddr), 0);
        step();
        rst_n = 1'b1;
        step();
        chk("b_post_rst_in_ready", 32'(b_in_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
